lsu_obi_pipelined: RTL and testbench
====================================

// Module: lsu_obi_pipelined
// PURPOSE
//  Parametrised load/store unit between EXEC and a data memory with an OBI-style req/gnt/rvalid port.
//  Supports up to MAX_OUTSTANDING granted-but-unanswered transactions, with in-order responses and RV32I
//  sizing/sign-extension. Misaligned accesses are trapped locally and never reach memory.
// PARAMETERS
//  MAX_OUTSTANDING  2          max granted transactions awaiting rvalid (>=1)
//  TAG_W            5          width of core tag (e.g. rd index) echoed on response
//  MEM_OFFSET       32'h0      subtracted from core address before driving data_addr_o
// PORTS
//  clk              in   1      clock
//  reset            in   1      synchronous, active-high reset
//  stop_i           in   1      blocks acceptance of new core requests
//  core_req_valid   in   1      core request valid
//  core_req_ready   out  1      unit accepts request this cycle
//  core_req_we      in   1      1=store 0=load
//  core_req_funct3  in   3      000 B,001 H,010 W,100 BU,101 HU (stores: 000/001/010 only)
//  core_req_addr    in   32     byte address (pre-offset)
//  core_req_wdata   in   32     store data, LSB-aligned
//  core_req_tag     in   TAG_W  opaque tag
//  rsp_valid        out  1      response valid (one cycle per transaction)
//  rsp_we           out  1      response belongs to a store
//  rsp_rdata        out  32     sized/extended load data; 0 for stores
//  rsp_tag          out  TAG_W  tag of the responding transaction
//  misaligned_o     out  1      one-cycle pulse: last accepted request was misaligned
//  misaligned_addr_o out 32     offending core address, valid with misaligned_o
//  proto_err_o      out  1      sticky: rvalid seen with no outstanding transaction
//  idle_o           out  1      no pending request and zero outstanding
//  data_req_o/data_addr_o[32]/data_we_o/data_be_o[4]/data_wdata_o[32]  out  memory request channel
//  data_gnt_i/data_rvalid_i/data_rdata_i[32]                            in   memory grant/response
// BEHAVIOUR
//  - Reset: req_pending=0, outstanding=0, FIFO empty, proto_err_o=0, misaligned_o=0; all data_* outputs 0; idle_o=1.
//  - core_req_ready = ~req_pending & (outstanding < MAX_OUTSTANDING) & ~stop_i.
//  - Handshake: accept on core_req_valid & core_req_ready. An aligned request is registered; data_req_o=1 from the next cycle.
//  - Misalignment: W with addr[1:0]!=0, or H/HU/SH with addr[0]=1. The request is consumed but not registered;
//    misaligned_o=1 next cycle; no memory access and no response.
//  - While data_req_o=1, addr/we/be/wdata are held stable until data_gnt_i. On gnt, req_pending clears in the same cycle.
//    A new accept is possible the following cycle (no same-cycle re-accept).
//  - data_addr_o = core_req_addr - MEM_OFFSET (32-bit wrap).
//  - Loads: be=4'b1111, we=0.
//  - Stores: SB be=0001<<off with byte replicated into lane off. SH be=0011 (off<2) or 1100, halfword in the matching lanes.
//    SW be=1111. Unused wdata lanes are 0.
//  - On gnt: push {tag, funct3, addr[1:0], we} into an in-order metadata FIFO of depth MAX_OUTSTANDING; outstanding+1.
//  - On rvalid: pop the FIFO head. rsp_valid=data_rvalid_i in the same cycle (combinational), with rsp_tag/rsp_we from the head.
//    rsp_rdata is extracted from lane addr[1:0]: B/H sign-extended, BU/HU zero-extended, W raw.
//  - gnt and rvalid in the same cycle: push and pop together; outstanding unchanged.
//    rvalid for a transaction arrives no earlier than the cycle after its gnt.
//  - rvalid with outstanding==0: ignored, no rsp_valid, proto_err_o set (cleared only by reset).
//  - FIFO full: core_req_ready=0. A pending un-granted request still waits for gnt, but a full FIFO never drives data_req_o.
//  - stop_i only gates acceptance. A pending request and outstanding responses always complete.
//  - Reset mid-operation clears all state. Later rvalids from pre-reset transactions raise proto_err_o.
//  - idle_o = ~req_pending & (outstanding==0).
// TESTING
//  LW 0x1000, gnt same cycle as req, rvalid +1 with rdata 0xDEADBEEF -> rsp_rdata=0xDEADBEEF, tag echoed, idle_o=1 after.
//  LB addr 0x1003, rdata 0x80FF0000 -> rsp_rdata=0xFFFFFF80; LHU addr 0x1002 -> 0x000080FF.
//  SB 0x2001, wdata 0xAB -> data_be_o=0010, data_wdata_o=0x0000AB00, data_we_o=1; rsp_we=1, rsp_rdata=0.
//  MAX_OUTSTANDING=2, three back-to-back LW, rvalid held 0 -> third waits with ready=0.
//    Then rvalids -> responses in tag order 1,2,3.
//  LW 0x1002 -> misaligned_o pulse with addr 0x1002, data_req_o stays 0, no rsp_valid.
//  gnt delayed 3 cycles -> addr/be stable throughout. rvalid with empty FIFO -> proto_err_o=1 sticky.

Source files
------------

// File: rtl/lsu_obi_pipelined.sv
// Load/store unit bridging EXEC requests onto an OBI-style req/gnt/rvalid data port.
// One request can wait for grant while up to MAX_OUTSTANDING granted transactions
// wait for rvalid. Responses come back in order, and a small metadata FIFO keeps
// what is needed to size and sign-extend each load result. Misaligned accesses
// are trapped here and never reach memory.
module lsu_obi_pipelined #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          TAG_W           = 5,
    parameter logic [31:0] MEM_OFFSET      = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop_i,
    input  logic             core_req_valid,
    output logic             core_req_ready,
    input  logic             core_req_we,
    input  logic [2:0]       core_req_funct3,
    input  logic [31:0]      core_req_addr,
    input  logic [31:0]      core_req_wdata,
    input  logic [TAG_W-1:0] core_req_tag,
    output logic             rsp_valid,
    output logic             rsp_we,
    output logic [31:0]      rsp_rdata,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             misaligned_o,
    output logic [31:0]      misaligned_addr_o,
    output logic             proto_err_o,
    output logic             idle_o,
    output logic             data_req_o,
    output logic [31:0]      data_addr_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [31:0]      data_wdata_o,
    input  logic             data_gnt_i,
    input  logic             data_rvalid_i,
    input  logic [31:0]      data_rdata_i
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Everything needed to turn a raw rvalid word into a core response.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [2:0]       funct3;
        logic [1:0]       off;
        logic             we;
    } meta_t;

    logic             req_pending;
    meta_t            pend_meta;
    meta_t            fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             accept;
    logic             misaligned;
    logic             gnt_fire;
    logic             pop;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    meta_t            head;
    logic [31:0]      lane_data;
    logic [31:0]      load_data;

    assign fifo_full      = (count == CNT_W'(MAX_OUTSTANDING));
    assign core_req_ready = ~req_pending & ~fifo_full & ~stop_i;
    assign accept         = core_req_valid & core_req_ready;
    // A full FIFO has no slot for the grant metadata, so the request is held back.
    assign data_req_o     = req_pending & ~fifo_full;
    assign gnt_fire       = data_req_o & data_gnt_i;
    assign pop            = data_rvalid_i & (count != '0);
    assign idle_o         = ~req_pending & (count == '0);

    // Alignment rule: funct3[1:0] gives the access size (00 byte, 01 half, else word).
    always_comb begin
        misaligned = 1'b0;
        case (core_req_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = core_req_addr[0];
            default: misaligned = (core_req_addr[1:0] != 2'b00);
        endcase
    end

    // Byte enables and lane placement of store data; loads read the whole word.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        if (core_req_we) begin
            case (core_req_funct3[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << core_req_addr[1:0];
                    wdata_next = {24'h0, core_req_wdata[7:0]} << {core_req_addr[1:0], 3'b000};
                end
                2'b01: begin
                    if (core_req_addr[1]) begin
                        be_next    = 4'b1100;
                        wdata_next = {core_req_wdata[15:0], 16'h0};
                    end else begin
                        be_next    = 4'b0011;
                        wdata_next = {16'h0, core_req_wdata[15:0]};
                    end
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = core_req_wdata;
                end
            endcase
        end
    end

    // Request register: holds the memory request stable until it is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pending  <= 1'b0;
            pend_meta    <= '0;
            data_addr_o  <= 32'h0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'h0;
            data_wdata_o <= 32'h0;
        end else begin
            if (gnt_fire) begin
                req_pending <= 1'b0;
            end
            if (accept && !misaligned) begin
                req_pending      <= 1'b1;
                pend_meta.tag    <= core_req_tag;
                pend_meta.funct3 <= core_req_funct3;
                pend_meta.off    <= core_req_addr[1:0];
                pend_meta.we     <= core_req_we;
                data_addr_o      <= core_req_addr - MEM_OFFSET;
                data_we_o        <= core_req_we;
                data_be_o        <= be_next;
                data_wdata_o     <= wdata_next;
            end
        end
    end

    // Metadata storage; contents are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (gnt_fire) begin
            fifo_mem[wr_ptr] <= pend_meta;
        end
    end

    // FIFO pointers and occupancy; occupancy doubles as the outstanding count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (gnt_fire) begin
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({gnt_fire, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Misalignment pulse and sticky protocol error for orphan rvalids.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_o      <= 1'b0;
            misaligned_addr_o <= 32'h0;
            proto_err_o       <= 1'b0;
        end else begin
            misaligned_o <= accept & misaligned;
            if (accept && misaligned) begin
                misaligned_addr_o <= core_req_addr;
            end
            if (data_rvalid_i && (count == '0)) begin
                proto_err_o <= 1'b1;
            end
        end
    end

    assign head      = fifo_mem[rd_ptr];
    assign lane_data = data_rdata_i >> {head.off, 3'b000};

    // Size and extend the selected lane of the returned word.
    always_comb begin
        load_data = data_rdata_i;
        case (head.funct3)
            3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_data = {24'h0, lane_data[7:0]};
            3'b101:  load_data = {16'h0, lane_data[15:0]};
            default: load_data = data_rdata_i;
        endcase
    end

    assign rsp_valid = pop;
    assign rsp_we    = pop & head.we;
    assign rsp_tag   = pop ? head.tag : '0;
    assign rsp_rdata = (pop && !head.we) ? load_data : 32'h0;

endmodule

// File: tb/tb_lsu_obi_pipelined.sv
// Bench for lsu_obi_pipelined: a table of single transactions plus hand-written
// sequences for back-pressure, delayed grant, misalignment, orphan rvalid and reset.
module tb_lsu_obi_pipelined;

    localparam logic [31:0] OFF = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        stop_i;
    logic        core_req_valid;
    logic        core_req_ready;
    logic        core_req_we;
    logic [2:0]  core_req_funct3;
    logic [31:0] core_req_addr;
    logic [31:0] core_req_wdata;
    logic [4:0]  core_req_tag;
    logic        rsp_valid;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_tag;
    logic        misaligned_o;
    logic [31:0] misaligned_addr_o;
    logic        proto_err_o;
    logic        idle_o;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    lsu_obi_pipelined #(
        .MAX_OUTSTANDING(2),
        .TAG_W(5),
        .MEM_OFFSET(OFF)
    ) dut (
        .clk(clk), .reset(reset), .stop_i(stop_i),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_funct3(core_req_funct3),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_req_tag(core_req_tag),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
        .misaligned_o(misaligned_o), .misaligned_addr_o(misaligned_addr_o),
        .proto_err_o(proto_err_o), .idle_o(idle_o),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        logic [31:0] mem_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  tag;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic we, input logic [4:0] tag, input logic [31:0] rdata);
        exp_t e;
        e.we = we; e.tag = tag; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Present a request and hold it until accepted; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] tag);
        int n;
        core_req_valid  = 1'b1;
        core_req_we     = we;
        core_req_funct3 = f3;
        core_req_addr   = addr;
        core_req_wdata  = wdata;
        core_req_tag    = tag;
        #1;
        n = 0;
        while (!core_req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
        tick();
        core_req_valid = 1'b0;
    endtask

    // Scoreboard side: every response is popped and compared at the falling edge.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                check("rsp_we", 32'(rsp_we), 32'(e.we));
                check("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_1000, 32'h0,         5'd7,  32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,         5'd3,  32'h80FF_0000, 4'b1111, 32'h0,         32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 3'b101, 32'h0000_1002, 32'h0,         5'd4,  32'h80FF_0000, 4'b1111, 32'h0,         32'h0000_80FF};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_1002, 32'h0,         5'd5,  32'h80FF_0000, 4'b1111, 32'h0,         32'hFFFF_80FF};
        vecs[4]  = '{1'b0, 3'b100, 32'h0000_1001, 32'h0,         5'd6,  32'h1234_5678, 4'b1111, 32'h0,         32'h0000_0056};
        vecs[5]  = '{1'b0, 3'b001, 32'h0000_1000, 32'h0,         5'd8,  32'h0000_F00F, 4'b1111, 32'h0,         32'hFFFF_F00F};
        vecs[6]  = '{1'b1, 3'b000, 32'h0000_2001, 32'h1234_56AB, 5'd9,  32'hFFFF_FFFF, 4'b0010, 32'h0000_AB00, 32'h0};
        vecs[7]  = '{1'b1, 3'b001, 32'h0000_2002, 32'hCAFE_BEEF, 5'd10, 32'hFFFF_FFFF, 4'b1100, 32'hBEEF_0000, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h0000_2004, 32'h0102_0304, 5'd11, 32'h0,         4'b1111, 32'h0102_0304, 32'h0};
        vecs[9]  = '{1'b1, 3'b000, 32'h0000_2003, 32'h0000_005A, 5'd12, 32'h0,         4'b1000, 32'h5A00_0000, 32'h0};
        vecs[10] = '{1'b0, 3'b010, 32'h0000_0080, 32'h0,         5'd13, 32'h0000_0007, 4'b1111, 32'h0,         32'h0000_0007};

        reset = 1'b1; stop_i = 1'b0; core_req_valid = 1'b0; core_req_we = 1'b0;
        core_req_funct3 = 3'b0; core_req_addr = 32'h0; core_req_wdata = 32'h0; core_req_tag = 5'd0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        tick(); tick();
        check("rst_data_req", 32'(data_req_o), 32'd0);
        check("rst_data_addr", data_addr_o, 32'h0);
        check("rst_data_be", 32'(data_be_o), 32'h0);
        check("rst_idle", 32'(idle_o), 32'd1);
        check("rst_proto_err", 32'(proto_err_o), 32'd0);
        check("rst_misaligned", 32'(misaligned_o), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(core_req_ready), 32'd1);

        // Table: single transaction, grant in the first request cycle, rvalid one cycle later.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].tag);
            check("vec_data_req", 32'(data_req_o), 32'd1);
            check("vec_addr", data_addr_o, vecs[i].addr - OFF);
            check("vec_we", 32'(data_we_o), 32'(vecs[i].we));
            check("vec_be", 32'(data_be_o), 32'(vecs[i].exp_be));
            check("vec_wdata", data_wdata_o, vecs[i].exp_wdata);
            data_gnt_i = 1'b1;
            push_exp(vecs[i].we, vecs[i].tag, vecs[i].exp_rdata);
            tick();
            data_gnt_i = 1'b0;
            #1;
            check("vec_req_drop", 32'(data_req_o), 32'd0);
            data_rvalid_i = 1'b1;
            data_rdata_i  = vecs[i].mem_rdata;
            tick();
            data_rvalid_i = 1'b0;
            check("vec_idle_after", 32'(idle_o), 32'd1);
        end

        // Two outstanding fill the FIFO; a third request must wait.
        issue(1'b0, 3'b010, 32'h0000_1100, 32'h0, 5'd1);
        data_gnt_i = 1'b1; push_exp(1'b0, 5'd1, 32'hA1A1_A1A1); tick(); data_gnt_i = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_1104, 32'h0, 5'd2);
        data_gnt_i = 1'b1; push_exp(1'b0, 5'd2, 32'hA2A2_A2A2); tick(); data_gnt_i = 1'b0;
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_funct3 = 3'b010;
        core_req_addr = 32'h0000_1108; core_req_tag = 5'd3;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("full_ready", 32'(core_req_ready), 32'd0);
            check("full_data_req", 32'(data_req_o), 32'd0);
            tick();
        end
        core_req_valid = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hA1A1_A1A1; tick();
        data_rdata_i = 32'hA2A2_A2A2; tick();
        data_rvalid_i = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_1108, 32'h0, 5'd3);
        data_gnt_i = 1'b1; push_exp(1'b0, 5'd3, 32'hA3A3_A3A3); tick(); data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hA3A3_A3A3; tick(); data_rvalid_i = 1'b0;
        check("b2b_idle", 32'(idle_o), 32'd1);

        // Grant of the second transaction coincides with rvalid of the first.
        issue(1'b0, 3'b010, 32'h0000_1200, 32'h0, 5'd20);
        data_gnt_i = 1'b1; push_exp(1'b0, 5'd20, 32'hB0B0_0000); tick(); data_gnt_i = 1'b0;
        issue(1'b0, 3'b100, 32'h0000_1202, 32'h0, 5'd21);
        data_gnt_i = 1'b1; push_exp(1'b0, 5'd21, 32'h0000_00B1);
        data_rvalid_i = 1'b1; data_rdata_i = 32'hB0B0_0000;
        tick();
        data_gnt_i = 1'b0;
        data_rdata_i = 32'h00B1_0000; tick();
        data_rvalid_i = 1'b0;
        check("overlap_idle", 32'(idle_o), 32'd1);

        // Grant delayed three cycles: request fields must not move.
        issue(1'b1, 3'b010, 32'h0000_3000, 32'h55AA_55AA, 5'd14);
        core_req_addr = 32'h0000_4444; core_req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("hold_req", 32'(data_req_o), 32'd1);
            check("hold_addr", data_addr_o, 32'h0000_3000 - OFF);
            check("hold_be", 32'(data_be_o), 32'hF);
            check("hold_wdata", data_wdata_o, 32'h55AA_55AA);
            check("hold_ready", 32'(core_req_ready), 32'd0);
            tick();
        end
        data_gnt_i = 1'b1; push_exp(1'b1, 5'd14, 32'h0); tick(); data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678; tick(); data_rvalid_i = 1'b0;

        // stop_i blocks acceptance.
        stop_i = 1'b1; core_req_valid = 1'b1; core_req_addr = 32'h0000_1000; core_req_funct3 = 3'b010;
        #1;
        check("stop_ready", 32'(core_req_ready), 32'd0);
        tick();
        check("stop_no_req", 32'(data_req_o), 32'd0);
        core_req_valid = 1'b0; stop_i = 1'b0;

        // Misaligned accesses: one-cycle pulse, no memory request, no response.
        issue(1'b0, 3'b010, 32'h0000_1002, 32'h0, 5'd15);
        check("mis_pulse", 32'(misaligned_o), 32'd1);
        check("mis_addr", misaligned_addr_o, 32'h0000_1002);
        check("mis_no_req", 32'(data_req_o), 32'd0);
        tick();
        check("mis_pulse_end", 32'(misaligned_o), 32'd0);
        check("mis_no_req2", 32'(data_req_o), 32'd0);
        issue(1'b1, 3'b001, 32'h0000_2001, 32'h0, 5'd16);
        check("mis_sh_pulse", 32'(misaligned_o), 32'd1);
        check("mis_sh_addr", misaligned_addr_o, 32'h0000_2001);
        check("mis_sh_no_req", 32'(data_req_o), 32'd0);
        tick();
        check("mis_idle", 32'(idle_o), 32'd1);

        // Orphan rvalid sets a sticky protocol error.
        check("proto_before", 32'(proto_err_o), 32'd0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h0BAD_0BAD; tick(); data_rvalid_i = 1'b0;
        check("proto_set", 32'(proto_err_o), 32'd1);
        tick(); tick();
        check("proto_sticky", 32'(proto_err_o), 32'd1);

        // Reset with a transaction in flight; its late rvalid becomes an orphan.
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst2_proto", 32'(proto_err_o), 32'd0);
        issue(1'b0, 3'b010, 32'h0000_1300, 32'h0, 5'd30);
        data_gnt_i = 1'b1; tick(); data_gnt_i = 1'b0;
        check("inflight_busy", 32'(idle_o), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst3_idle", 32'(idle_o), 32'd1);
        check("rst3_data_req", 32'(data_req_o), 32'd0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_1111; tick(); data_rvalid_i = 1'b0;
        check("stale_rvalid_proto", 32'(proto_err_o), 32'd1);

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
